// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array matrix loader and writer.
package systolic_pkg;

    // Sequencing states for the matrix stream engines.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    // Address width for n linear elements; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/matrix_writer_if.sv
// Valid/ready write port carrying one matrix element per transfer.
interface matrix_writer_if #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/matrix_writer.sv
// Captures a parallel result matrix in one cycle and streams it row-major
// over a valid/ready write port (linear index = ARRAY_L*row + col).
module matrix_writer
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_W    = 4,
    parameter int unsigned ARRAY_L    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] data_res,
    output logic busy,
    output logic done,
    matrix_writer_if.master wr
);

    localparam int unsigned N      = ARRAY_W * ARRAY_L;
    localparam int unsigned ADDR_W = addr_width(N);
    localparam int unsigned ROW_W  = addr_width(ARRAY_W);
    localparam int unsigned COL_W  = addr_width(ARRAY_L);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ARRAY_L - 1);

    state_t state;
    state_t state_next;

    logic capture;
    logic advance;

    logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] captured;
    logic [ADDR_W-1:0] idx;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus capture/advance strobes for the datapath.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (wr.wr_ready) begin
                    if (idx == IDX_LAST) begin
                        state_next = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture register and linear/row/column counters; row and column
    // track idx so the element select needs no division.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured <= '0;
            idx      <= '0;
            row      <= '0;
            col      <= '0;
        end else if (capture) begin
            captured <= data_res;
            idx      <= '0;
            row      <= '0;
            col      <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        wr.wr_valid = (state == SEND);
        wr.wr_addr  = '0;
        wr.wr_data  = '0;
        if (state == SEND) begin
            wr.wr_addr = idx;
            wr.wr_data = captured[row][col];
        end
    end

endmodule

// File: tb/tb_matrix_writer.sv
// Directed + randomized checks of matrix_writer against a row-major
// element-list model derived from a snapshot of the matrix at capture.
module tb_matrix_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    logic rdy_a, rdy_b;
    logic [0:3][0:3][7:0]  data_a;
    logic [0:1][0:2][15:0] data_b;
    logic busy_a, done_a, busy_b, done_b;

    matrix_writer_if #(.ADDR_W(4), .DATA_WIDTH(8))  bus_a ();
    matrix_writer_if #(.ADDR_W(3), .DATA_WIDTH(16)) bus_b ();

    assign bus_a.wr_ready = rdy_a;
    assign bus_b.wr_ready = rdy_b;

    matrix_writer #(.DATA_WIDTH(8), .ARRAY_W(4), .ARRAY_L(4)) dut_a (
        .clk      (clk),
        .reset    (rst),
        .start    (start_a),
        .data_res (data_a),
        .busy     (busy_a),
        .done     (done_a),
        .wr       (bus_a)
    );

    matrix_writer #(.DATA_WIDTH(16), .ARRAY_W(2), .ARRAY_L(3)) dut_b (
        .clk      (clk),
        .reset    (rst),
        .start    (start_b),
        .data_res (data_b),
        .busy     (busy_b),
        .done     (done_b),
        .wr       (bus_b)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_a [16];
    int done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: element k of the snapshot is matrix[k/4][k%4].
    task automatic snap_a();
        for (int k = 0; k < 16; k++) begin
            exp_a[k] = data_a[k / 4][k % 4];
        end
    endtask

    task automatic fill_a_pattern();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                data_a[i][j] = 8'(8'h10 + 4 * i + j);
            end
        end
    endtask

    task automatic fill_a_random();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                data_a[i][j] = 8'($urandom);
            end
        end
    endtask

    // Entered in cycle 1 (just after the capture edge). Mode: 0 ready high,
    // 1 ready low in cycles 3-5, 2 random ready, 3 ready high while the
    // matrix is overwritten (cycle 2) and start pulsed (cycle 5).
    task automatic stream_a(input int mode, output int dcyc);
        int k;
        int cyc;
        k    = 0;
        cyc  = 1;
        dcyc = -1;
        while (dcyc < 0 && cyc < 300) begin
            case (mode)
                1:       rdy_a = !(cyc >= 3 && cyc <= 5);
                2:       rdy_a = 1'($urandom_range(0, 1));
                default: rdy_a = 1'b1;
            endcase
            if (mode == 3) begin
                if (cyc == 2) data_a = '1;
                if (cyc == 5) start_a = 1'b1;
                if (cyc == 6) start_a = 1'b0;
            end
            if (k < 16) begin
                chk("send_valid", 32'(bus_a.wr_valid), 32'd1);
                chk("send_addr",  32'(bus_a.wr_addr),  32'(k));
                chk("send_data",  32'(bus_a.wr_data),  32'(exp_a[k]));
                chk("send_busy",  32'(busy_a),         32'd1);
                chk("send_done",  32'(done_a),         32'd0);
                if (rdy_a) k++;
            end else begin
                chk("done_pulse", 32'(done_a),         32'd1);
                chk("done_valid", 32'(bus_a.wr_valid), 32'd0);
                chk("done_busy",  32'(busy_a),         32'd1);
                dcyc = cyc;
            end
            step();
            cyc++;
        end
        if (dcyc < 0) chk("stream_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_valid"}, 32'(bus_a.wr_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy_a),         32'd0);
        chk({tag, "_done"},  32'(done_a),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        rdy_a   = 1'b0;
        rdy_b   = 1'b1;
        data_a  = '0;
        data_b  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        chk("rst_valid_a", 32'(bus_a.wr_valid), 32'd0);
        chk("rst_addr_a",  32'(bus_a.wr_addr),  32'd0);
        chk("rst_data_a",  32'(bus_a.wr_data),  32'd0);
        chk("rst_busy_a",  32'(busy_a),         32'd0);
        chk("rst_done_a",  32'(done_a),         32'd0);
        chk("rst_valid_b", 32'(bus_b.wr_valid), 32'd0);
        chk("rst_busy_b",  32'(busy_b),         32'd0);
        rst = 1'b0;
        step();

        // 1: full-rate stream of the 8'h10+4i+j matrix.
        fill_a_pattern();
        snap_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        stream_a(0, done_cyc);
        chk("t1_done_cycle", 32'(done_cyc), 32'd17);
        chk_idle_a("t1_idle");

        // 2: back-pressure in cycles 3-5.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        stream_a(1, done_cyc);
        chk("t2_done_cycle", 32'(done_cyc), 32'd20);
        chk_idle_a("t2_idle");

        // 3: matrix overwritten and start pulsed mid-stream.
        fill_a_pattern();
        snap_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        stream_a(3, done_cyc);
        chk("t3_done_cycle", 32'(done_cyc), 32'd17);
        chk_idle_a("t3_idle0");
        step();
        chk_idle_a("t3_idle1");

        // 4: asynchronous reset with addr 7 pending, then random restart.
        fill_a_pattern();
        snap_a();
        rdy_a   = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (7) step();
        chk("t4_pending_addr", 32'(bus_a.wr_addr), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_valid", 32'(bus_a.wr_valid), 32'd0);
        chk("t4_async_busy",  32'(busy_a),         32'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_a_random();
        snap_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        stream_a(2, done_cyc);
        chk_idle_a("t4_idle");

        // 5: start held high -> recapture in the first IDLE cycle.
        fill_a_random();
        snap_a();
        start_a = 1'b1;
        step();
        stream_a(0, done_cyc);
        chk("t5_done_cycle", 32'(done_cyc), 32'd17);
        chk_idle_a("t5_gap");
        fill_a_random();
        snap_a();
        step();
        start_a = 1'b0;
        stream_a(0, done_cyc);
        chk("t5_second_done", 32'(done_cyc), 32'd17);

        // 6: 2x3 matrix of 16-bit elements.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                data_b[i][j] = 16'(16'hA000 + (i << 4) + j);
            end
        end
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("t6_valid", 32'(bus_b.wr_valid), 32'd1);
            chk("t6_addr",  32'(bus_b.wr_addr),  32'(c));
            chk("t6_data",  32'(bus_b.wr_data),  32'(16'hA000 + 16 * (c / 3) + (c % 3)));
            step();
        end
        chk("t6_done",  32'(done_b),         32'd1);
        chk("t6_dvld",  32'(bus_b.wr_valid), 32'd0);
        step();
        chk("t6_idle",  32'(busy_b),         32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
